// File: rtl/time_keeper_if.sv
// time_keeper_if: connection bundle between the time keeper and its
// neighbours (clock divider, debounced buttons, display mux).
//   tick_1hz  : one-cycle 1 Hz enable from the divider
//   btn_mode  : debounced mode button level
//   btn_up    : debounced increment button level
//   hour_bcd, min_bcd, sec_bcd : two-digit BCD time fields
//   mode      : 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   day_wrap  : one-cycle pulse on the midnight rollover
//   alarm_hour, alarm_min, alarm_hit : present only when ALARM_EN is defined
// Modports: master = stimulus/consumer side, slave = time_keeper.
interface time_keeper_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       day_wrap;
`ifdef ALARM_EN
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       alarm_hit;
`endif

  modport master (
    output tick_1hz, btn_mode, btn_up,
`ifdef ALARM_EN
    output alarm_hour, alarm_min,
    input  alarm_hit,
`endif
    input  hour_bcd, min_bcd, sec_bcd, mode, day_wrap
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up,
`ifdef ALARM_EN
    input  alarm_hour, alarm_min,
    output alarm_hit,
`endif
    output hour_bcd, min_bcd, sec_bcd, mode, day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: 24 h (or HOUR_WRAP h) BCD time-of-day counter HH:MM:SS.
// Advances on the 1 Hz enable pulse in RUN mode; the mode button cycles
// RUN -> SET_HOUR -> SET_MIN -> RUN and the up button bumps the selected
// field while setting. All outputs are registered.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : time_keeper_if.slave (tick, buttons, BCD time, mode, day_wrap)
// Parameters: HOUR_WRAP (2..24), INIT_HOUR (< HOUR_WRAP, loaded at reset).
// Optional feature macro: ALARM_EN (alarm_hour/alarm_min inputs, alarm_hit).
module time_keeper #(
  parameter int HOUR_WRAP = 24,
  parameter int INIT_HOUR = 0
) (
  input logic          clk,
  input logic          rst,
  time_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [7:0] INIT_BCD  = {4'(INIT_HOUR / 10), 4'(INIT_HOUR % 10)};
  localparam logic [7:0] HOUR_LAST = {4'((HOUR_WRAP - 1) / 10), 4'((HOUR_WRAP - 1) % 10)};
  localparam logic [7:0] BCD_59    = 8'h59;

  state_t     state;
  logic [7:0] hour, min, sec;
  logic       day_wrap;
  logic       mode_q, up_q;
  logic       mode_press, up_press;

  logic [7:0] sec_nx, min_nx, hour_nx;
  logic       sec_carry, min_carry, wrap_nx;

  // Two-digit BCD increment that returns to 00 after 'last'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)         return '0;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign mode_press = bus.btn_mode & ~mode_q;
  assign up_press   = bus.btn_up   & ~up_q;

  // Value the clock takes if a RUN-mode tick is applied this cycle.
  always_comb begin
    sec_nx    = bcd_inc(sec, BCD_59);
    sec_carry = (sec == BCD_59);
    min_carry = sec_carry && (min == BCD_59);
    min_nx    = sec_carry ? bcd_inc(min, BCD_59) : min;
    hour_nx   = min_carry ? bcd_inc(hour, HOUR_LAST) : hour;
    wrap_nx   = min_carry && (hour == HOUR_LAST);
  end

`ifdef ALARM_EN
  logic alarm_hit;
  logic alarm_match;
  assign alarm_match = (hour_nx == bus.alarm_hour) && (min_nx == bus.alarm_min) &&
                       (sec_nx == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_hit <= 1'b0;
    else     alarm_hit <= (state == RUN) && bus.tick_1hz && alarm_match;
  end

  assign bus.alarm_hit = alarm_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hour     <= INIT_BCD;
      min      <= '0;
      sec      <= '0;
      day_wrap <= 1'b0;
      mode_q   <= 1'b0;
      up_q     <= 1'b0;
    end else begin
      mode_q   <= bus.btn_mode;
      up_q     <= bus.btn_up;
      day_wrap <= 1'b0;
      case (state)
        RUN: begin
          // The tick still applies on the cycle that leaves RUN.
          if (bus.tick_1hz) begin
            sec      <= sec_nx;
            min      <= min_nx;
            hour     <= hour_nx;
            day_wrap <= wrap_nx;
          end
          if (mode_press) state <= SET_HOUR;
        end
        SET_HOUR: begin
          if (mode_press)    state <= SET_MIN;
          else if (up_press) hour  <= bcd_inc(hour, HOUR_LAST);
        end
        SET_MIN: begin
          if (mode_press) begin
            state <= RUN;
            sec   <= '0;
          end else if (up_press) begin
            min <= bcd_inc(min, BCD_59);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.hour_bcd = hour;
  assign bus.min_bcd  = min;
  assign bus.sec_bcd  = sec;
  assign bus.mode     = state;
  assign bus.day_wrap = day_wrap;

endmodule
